// File: rtl/score_sequencer_pkg.sv
// Shared definitions for the score sequencer: ROM entry layout, note divisors and FSM states.
package score_sequencer_pkg;

   localparam int unsigned DivW = 22;
   localparam int unsigned DurW = 6;
   localparam int unsigned IdxW = 4;

   localparam logic [DivW-1:0] SilentDiv = 22'd1;

   // Divisors are 50 MHz / f, rounded, for a 100 MHz generator that toggles on cnt == div.
   localparam logic [DivW-1:0] DivC4  = 22'd191110;
   localparam logic [DivW-1:0] DivCs4 = 22'd180388;
   localparam logic [DivW-1:0] DivD4  = 22'd170265;
   localparam logic [DivW-1:0] DivDs4 = 22'd160705;
   localparam logic [DivW-1:0] DivE4  = 22'd151685;
   localparam logic [DivW-1:0] DivF4  = 22'd143172;
   localparam logic [DivW-1:0] DivFs4 = 22'd135139;
   localparam logic [DivW-1:0] DivG4  = 22'd127551;
   localparam logic [DivW-1:0] DivGs4 = 22'd120395;
   localparam logic [DivW-1:0] DivA4  = 22'd113636;
   localparam logic [DivW-1:0] DivAs4 = 22'd107259;
   localparam logic [DivW-1:0] DivB4  = 22'd101239;
   localparam logic [DivW-1:0] DivC5  = 22'd95557;
   localparam logic [DivW-1:0] DivD5  = 22'd85131;
   localparam logic [DivW-1:0] DivE5  = 22'd75844;

   typedef struct packed {
      logic            end_flag;
      logic            rest;
      logic [DurW-1:0] dur;
      logic [IdxW-1:0] left_idx;
      logic [IdxW-1:0] right_idx;
   } entry_t;

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StLoad,
      StHold,
      StPaused,
      StDone
   } state_e;

   // A zero duration plays as a single tick.
   function automatic logic [DurW-1:0] last_tick(input logic [DurW-1:0] dur);
      return (dur == '0) ? '0 : dur - 1'b1;
   endfunction

endpackage

// File: rtl/score_sequencer_note_lut.sv
// Maps a 4-bit note index to the generator divisor; index 0 is silence.
module score_sequencer_note_lut
   import score_sequencer_pkg::*;
(
   input  logic [IdxW-1:0] idx,
   output logic [DivW-1:0] div
);

   always_comb begin
      div = SilentDiv;
      case (idx)
         4'd1:    div = DivC4;
         4'd2:    div = DivCs4;
         4'd3:    div = DivD4;
         4'd4:    div = DivDs4;
         4'd5:    div = DivE4;
         4'd6:    div = DivF4;
         4'd7:    div = DivFs4;
         4'd8:    div = DivG4;
         4'd9:    div = DivGs4;
         4'd10:   div = DivA4;
         4'd11:   div = DivAs4;
         4'd12:   div = DivB4;
         4'd13:   div = DivC5;
         4'd14:   div = DivD5;
         4'd15:   div = DivE5;
         default: div = SilentDiv;
      endcase
   end

endmodule

// File: rtl/score_sequencer.sv
// Two-voice score player: walks the score ROM, times each note in tempo ticks and drives the
// stereo note generator with divisors and a play gate.
module score_sequencer
   import score_sequencer_pkg::*;
#(
   parameter int unsigned ADDR_W   = 8,
   parameter int unsigned TICK_CYC = 12_500_000,
   parameter int unsigned GAP_CYC  = 1_000_000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              stop,
   input  logic              pause,
   input  logic              loop_en,
   input  logic [15:0]       score_data,
   output logic [ADDR_W-1:0] score_addr,
   output logic [DivW-1:0]   note_div_left,
   output logic [DivW-1:0]   note_div_right,
   output logic              play,
   output logic              busy,
   output logic              done
);

   localparam int unsigned CycW = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
   localparam logic [CycW-1:0] CycLast = CycW'(TICK_CYC - 1);
   localparam logic [CycW-1:0] GapCyc  = CycW'(GAP_CYC);

   state_e          state_q;
   logic            end_q;
   logic            rest_q;
   logic [IdxW-1:0] left_q;
   logic [IdxW-1:0] right_q;
   logic [DurW-1:0] tick_q;
   logic [CycW-1:0] cyc_q;

   entry_t          rom_entry;
   logic [DurW-1:0] tick_adv;
   logic [CycW-1:0] cyc_adv;
   logic            hold_final;
   logic            gap_adv;
   logic            gap_cur;
   logic            sound_next;
   logic [IdxW-1:0] left_sel;
   logic [IdxW-1:0] right_sel;
   logic [DivW-1:0] div_left;
   logic [DivW-1:0] div_right;

   assign rom_entry = entry_t'(score_data);

   // The entry is still on the ROM bus during LOAD, so look it up directly there.
   assign left_sel  = (state_q == StLoad) ? rom_entry.left_idx  : left_q;
   assign right_sel = (state_q == StLoad) ? rom_entry.right_idx : right_q;

   score_sequencer_note_lut u_lut_left (
      .idx (left_sel),
      .div (div_left)
   );

   score_sequencer_note_lut u_lut_right (
      .idx (right_sel),
      .div (div_right)
   );

   always_comb begin
      tick_adv = tick_q;
      cyc_adv  = cyc_q - 1'b1;
      if (cyc_q == '0) begin
         tick_adv = tick_q - 1'b1;
         cyc_adv  = CycLast;
      end
   end

   assign hold_final = (tick_q == '0) && (cyc_q == '0);
   assign gap_adv    = (tick_adv == '0) && (cyc_adv < GapCyc);
   assign gap_cur    = (tick_q == '0) && (cyc_q < GapCyc);

   // Whether the generator sounds in the cycle after this edge.
   always_comb begin
      sound_next = 1'b0;
      if (!stop) begin
         case (state_q)
            StLoad:   sound_next = !rom_entry.rest && !pause;
            StHold:   sound_next = !rest_q && !pause && !hold_final && !gap_adv;
            StPaused: sound_next = (start || !pause) && !rest_q && !gap_cur;
            default:  sound_next = 1'b0;
         endcase
      end
   end

   assign busy = (state_q != StIdle) && (state_q != StDone);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= StIdle;
         score_addr     <= '0;
         end_q          <= 1'b0;
         rest_q         <= 1'b0;
         left_q         <= '0;
         right_q        <= '0;
         tick_q         <= '0;
         cyc_q          <= '0;
         note_div_left  <= SilentDiv;
         note_div_right <= SilentDiv;
         play           <= 1'b0;
         done           <= 1'b0;
      end else begin
         done           <= 1'b0;
         play           <= sound_next;
         note_div_left  <= sound_next ? div_left  : SilentDiv;
         note_div_right <= sound_next ? div_right : SilentDiv;
         if (stop) begin
            state_q    <= StIdle;
            score_addr <= '0;
            tick_q     <= '0;
            cyc_q      <= '0;
         end else begin
            case (state_q)
               StIdle, StDone: begin
                  if (start) begin
                     score_addr <= '0;
                     state_q    <= StFetch;
                  end
               end
               StFetch: state_q <= StLoad;
               StLoad: begin
                  end_q   <= rom_entry.end_flag;
                  rest_q  <= rom_entry.rest;
                  left_q  <= rom_entry.left_idx;
                  right_q <= rom_entry.right_idx;
                  tick_q  <= last_tick(rom_entry.dur);
                  cyc_q   <= CycLast;
                  state_q <= pause ? StPaused : StHold;
               end
               StHold: begin
                  if (hold_final) begin
                     if (!end_q) begin
                        score_addr <= score_addr + 1'b1;
                        state_q    <= StFetch;
                     end else if (loop_en) begin
                        score_addr <= '0;
                        state_q    <= StFetch;
                     end else begin
                        state_q <= StDone;
                        done    <= 1'b1;
                     end
                  end else begin
                     // The pausing cycle still counts, so resuming replays no cycle twice.
                     tick_q <= tick_adv;
                     cyc_q  <= cyc_adv;
                     if (pause) begin
                        state_q <= StPaused;
                     end
                  end
               end
               StPaused: begin
                  if (start || !pause) begin
                     state_q <= StHold;
                  end
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_score_sequencer.sv
// Self-checking bench for score_sequencer against a remaining-cycles reference model.
module tb_score_sequencer;

   localparam int AddrW   = 8;
   localparam int TickCyc = 10;
   localparam int GapCyc  = 2;

   localparam int MIdle   = 0;
   localparam int MOvh    = 1;
   localparam int MNote   = 2;
   localparam int MPaused = 3;
   localparam int MDone   = 4;

   localparam logic [54:0] RstVec = {8'd0, 1'b0, 22'd1, 22'd1, 1'b0, 1'b0};

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic             stop;
   logic             pause;
   logic             loop_en;
   logic [15:0]      score_data;
   logic [AddrW-1:0] score_addr;
   logic [21:0]      note_div_left;
   logic [21:0]      note_div_right;
   logic             play;
   logic             busy;
   logic             done;
   logic [54:0]      dut_vec;

   logic [15:0] rom [256];

   int unsigned div_tab [16] = '{1, 191110, 180388, 170265, 160705, 151685, 143172, 135139,
                                 127551, 120395, 113636, 107259, 101239, 95557, 85131, 75844};

   int vectors     = 0;
   int miscompares = 0;

   int          m_mode;
   int          m_ovh;
   int          m_rem;
   int          m_addr;
   logic [15:0] m_entry;
   logic        m_done;

   always #5 clk = ~clk;

   always @(posedge clk) score_data <= rom[score_addr];

   assign dut_vec = {score_addr, play, note_div_left, note_div_right, busy, done};

   score_sequencer #(
      .ADDR_W   (AddrW),
      .TICK_CYC (TickCyc),
      .GAP_CYC  (GapCyc)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .stop           (stop),
      .pause          (pause),
      .loop_en        (loop_en),
      .score_data     (score_data),
      .score_addr     (score_addr),
      .note_div_left  (note_div_left),
      .note_div_right (note_div_right),
      .play           (play),
      .busy           (busy),
      .done           (done)
   );

   function automatic void m_reset();
      m_mode  = MIdle;
      m_ovh   = 0;
      m_rem   = 0;
      m_addr  = 0;
      m_entry = '0;
      m_done  = 1'b0;
   endfunction

   // Advance the model by one clock edge using the inputs the DUT sees at that edge.
   function automatic void m_step();
      m_done = 1'b0;
      if (stop) begin
         m_mode = MIdle;
         m_addr = 0;
      end else begin
         case (m_mode)
            MIdle, MDone: begin
               if (start) begin
                  m_mode = MOvh;
                  m_ovh  = 2;
                  m_addr = 0;
               end
            end
            MOvh: begin
               m_ovh--;
               if (m_ovh == 0) begin
                  m_entry = rom[m_addr];
                  m_rem   = ((m_entry[13:8] == 0) ? 1 : int'(m_entry[13:8])) * TickCyc;
                  m_mode  = pause ? MPaused : MNote;
               end
            end
            MNote: begin
               if (m_rem == 1) begin
                  if (!m_entry[15]) begin
                     m_addr = (m_addr + 1) % 256;
                     m_mode = MOvh;
                     m_ovh  = 2;
                  end else if (loop_en) begin
                     m_addr = 0;
                     m_mode = MOvh;
                     m_ovh  = 2;
                  end else begin
                     m_mode = MDone;
                     m_done = 1'b1;
                  end
               end else begin
                  m_rem--;
                  if (pause) m_mode = MPaused;
               end
            end
            MPaused: if (start || !pause) m_mode = MNote;
            default: m_mode = MIdle;
         endcase
      end
   endfunction

   function automatic logic [54:0] m_vec();
      logic        snd;
      logic        bsy;
      logic [21:0] dl;
      logic [21:0] dr;
      snd = (m_mode == MNote) && !m_entry[14] && (m_rem > GapCyc);
      bsy = (m_mode == MOvh) || (m_mode == MNote) || (m_mode == MPaused);
      dl  = snd ? 22'(div_tab[m_entry[7:4]]) : 22'd1;
      dr  = snd ? 22'(div_tab[m_entry[3:0]]) : 22'd1;
      return {8'(m_addr), snd, dl, dr, bsy, m_done};
   endfunction

   task automatic cycle();
      @(posedge clk);
      m_step();
      #1;
   endtask

   task automatic pulse_stop();
      stop = 1'b1;
      cycle();
      stop = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0; loop_en = 1'b0;
      for (int a = 0; a < 256; a++) rom[a] = '0;
      m_reset();
      for (int i = 0; i < 3; i++) begin
         cycle();
         vectors++;
         if (dut_vec !== RstVec) begin
            miscompares++;
            $display("FAIL reset[%0d]: got %h expected %h", i, dut_vec, RstVec);
         end
      end
      rst = 1'b1;
   endtask

   task automatic test_single();
      int plays = 0;
      int dones = 0;
      rom[0] = 16'h02A1;
      rom[1] = 16'hC100;
      loop_en = 1'b0;
      start = 1'b1;
      for (int i = 0; i < 45; i++) begin
         cycle();
         start = 1'b0;
         vectors++;
         if (dut_vec !== m_vec()) begin
            miscompares++;
            $display("FAIL single[%0d]: got %h expected %h", i, dut_vec, m_vec());
         end
         plays += int'(play);
         dones += int'(done);
      end
      vectors++;
      if (plays != 18) begin
         miscompares++;
         $display("FAIL single_play_cycles: got %0d expected 18", plays);
      end
      vectors++;
      if (dones != 1) begin
         miscompares++;
         $display("FAIL single_done_pulses: got %0d expected 1", dones);
      end
   endtask

   task automatic test_loop();
      int dones  = 0;
      int replay = 0;
      logic [AddrW-1:0] prev;
      loop_en = 1'b1;
      start = 1'b1;
      prev = score_addr;
      for (int i = 0; i < 80; i++) begin
         cycle();
         start = 1'b0;
         vectors++;
         if (dut_vec !== m_vec()) begin
            miscompares++;
            $display("FAIL loop[%0d]: got %h expected %h", i, dut_vec, m_vec());
         end
         dones += int'(done);
         if (prev == 1 && score_addr == 0) replay++;
         prev = score_addr;
      end
      vectors++;
      if (dones != 0 || replay < 1) begin
         miscompares++;
         $display("FAIL loop_replay: done pulses %0d replays %0d, expected 0 and >=1", dones, replay);
      end
      loop_en = 1'b0;
      pulse_stop();
   endtask

   task automatic test_pause();
      int plays = 0;
      int dur;
      int lead;
      dur  = int'($urandom_range(4, 2));
      lead = int'($urandom_range(12, 4));
      rom[0] = {1'b1, 1'b0, 6'(dur), 4'($urandom_range(15, 1)), 4'($urandom_range(15, 1))};
      loop_en = 1'b0;
      start = 1'b1;
      for (int i = 0; i < dur * TickCyc + 35; i++) begin
         cycle();
         start = 1'b0;
         vectors++;
         if (dut_vec !== m_vec()) begin
            miscompares++;
            $display("FAIL pause[%0d]: got %h expected %h", i, dut_vec, m_vec());
         end
         plays += int'(play);
         pause = (i >= lead) && (i < lead + 25);
      end
      pause = 1'b0;
      vectors++;
      if (plays != dur * TickCyc - GapCyc) begin
         miscompares++;
         $display("FAIL pause_play_cycles: got %0d expected %0d", plays, dur * TickCyc - GapCyc);
      end
   endtask

   task automatic test_stop_start();
      rom[0] = {1'b1, 1'b0, 6'd5, 4'($urandom_range(15, 1)), 4'($urandom_range(15, 1))};
      start = 1'b1;
      for (int i = 0; i < 8; i++) begin
         cycle();
         start = 1'b0;
         vectors++;
         if (dut_vec !== m_vec()) begin
            miscompares++;
            $display("FAIL stop_lead[%0d]: got %h expected %h", i, dut_vec, m_vec());
         end
      end
      start = 1'b1;
      stop  = 1'b1;
      cycle();
      start = 1'b0;
      stop  = 1'b0;
      vectors++;
      if (score_addr !== 8'd0 || play !== 1'b0 || busy !== 1'b0 || note_div_left !== 22'd1) begin
         miscompares++;
         $display("FAIL stop_start: addr %0d play %b busy %b divl %0d, expected 0 0 0 1",
                  score_addr, play, busy, note_div_left);
      end
      for (int i = 0; i < 4; i++) begin
         cycle();
         vectors++;
         if (dut_vec !== m_vec()) begin
            miscompares++;
            $display("FAIL stop_idle[%0d]: got %h expected %h", i, dut_vec, m_vec());
         end
      end
   endtask

   task automatic test_dur0_wrap();
      int first_move = 0;
      bit wrapped = 1'b0;
      logic [AddrW-1:0] prev;
      for (int a = 0; a < 256; a++) begin
         rom[a] = {1'b0, 1'($urandom_range(3, 0) == 0), 6'(a % 2), 4'($urandom), 4'($urandom)};
      end
      start = 1'b1;
      prev = score_addr;
      for (int i = 1; i <= 256 * 12 + 8; i++) begin
         cycle();
         start = 1'b0;
         vectors++;
         if (dut_vec !== m_vec()) begin
            miscompares++;
            $display("FAIL wrap[%0d]: got %h expected %h", i, dut_vec, m_vec());
         end
         if (first_move == 0 && score_addr == 1) first_move = i;
         if (prev == 255 && score_addr == 0) wrapped = 1'b1;
         prev = score_addr;
      end
      vectors++;
      if (first_move != 3 + TickCyc) begin
         miscompares++;
         $display("FAIL dur0_length: advanced after %0d cycles expected %0d", first_move,
                  3 + TickCyc);
      end
      vectors++;
      if (!wrapped) begin
         miscompares++;
         $display("FAIL addr_wrap: seen %b expected 1", wrapped);
      end
      pulse_stop();
   endtask

   task automatic test_random();
      for (int a = 0; a < 8; a++) begin
         rom[a] = {1'(a == 7), 1'($urandom_range(3, 0) == 0), 6'($urandom_range(3, 0)),
                   4'($urandom), 4'($urandom)};
      end
      loop_en = 1'($urandom_range(1, 0));
      start = 1'b1;
      for (int i = 0; i < 800; i++) begin
         cycle();
         vectors++;
         if (dut_vec !== m_vec()) begin
            miscompares++;
            $display("FAIL random[%0d]: got %h expected %h", i, dut_vec, m_vec());
         end
         start = ($urandom_range(31, 0) == 0);
         stop  = ($urandom_range(199, 0) == 0);
         if ($urandom_range(15, 0) == 0) pause = !pause;
         if ($urandom_range(99, 0) == 0) loop_en = !loop_en;
      end
      start = 1'b0;
      stop  = 1'b0;
      pause = 1'b0;
      loop_en = 1'b0;
      pulse_stop();
   endtask

   task automatic test_reset_mid();
      rom[0] = {1'b1, 1'b0, 6'd4, 4'd5, 4'd9};
      start = 1'b1;
      for (int i = 0; i < 8; i++) begin
         cycle();
         start = 1'b0;
         vectors++;
         if (dut_vec !== m_vec()) begin
            miscompares++;
            $display("FAIL rst_lead[%0d]: got %h expected %h", i, dut_vec, m_vec());
         end
      end
      #3 rst = 1'b0;
      #1;
      vectors++;
      if (dut_vec !== RstVec) begin
         miscompares++;
         $display("FAIL rst_async: got %h expected %h", dut_vec, RstVec);
      end
      m_reset();
      cycle();
      cycle();
      rst = 1'b1;
      start = 1'b1;
      for (int i = 0; i < 48; i++) begin
         cycle();
         start = 1'b0;
         vectors++;
         if (dut_vec !== m_vec()) begin
            miscompares++;
            $display("FAIL rst_replay[%0d]: got %h expected %h", i, dut_vec, m_vec());
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_loop();
      test_pause();
      test_stop_start();
      test_dur0_wrap();
      test_random();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
